tc_bridge_intc: RTL and testbench
=================================

// Module: tc_bridge_intc
// PURPOSE
//  Shares the CPU's device address space among N_TC timer/counter instances
//  and owns their interrupt lines. Sits between the CPU memory stage and the
//  timers. It decodes PrAddr into per-timer write enables and muxes read data.
//  It latches timer IRQ rising edges into pending bits, applies a mask, reports
//  overruns and the highest-priority source, and drives the 6-bit HWInt to CP0.
// PARAMETERS
//  N_TC      2          number of timers, 1..4; timer i occupies TC_BASE+16*i .. +11
//  TC_BASE   32'h7F00   byte base of timer 0
//  IC_BASE   32'h7F40   byte base of controller registers (PEND, MASK, VEC)
// PORTS
//  clk      in   1        clock, all state on posedge
//  reset    in   1        synchronous, active-high
//  PrAddr   in   30       CPU word address [31:2]
//  PrWE     in   1        CPU write strobe
//  PrWD     in   32       CPU write data
//  PrRD     out  32       read data to CPU (combinational)
//  DEV_Addr out  30       PrAddr forwarded to all timers
//  DEV_WD   out  32       PrWD forwarded to all timers
//  TC_WE    out  N_TC     per-timer write enable
//  TC_RD    in   32*N_TC  timer read data, timer i at [32i+31:32i]
//  TC_IRQ   in   N_TC     level IRQ from each timer
//  EXT_IRQ  in   6-N_TC   other device interrupts, passed straight through
//  HWInt    out  6        {EXT_IRQ, PEND[N_TC-1:0] & MASK}
// BEHAVIOUR
//  Decode is combinational. The hit window is 4 words per timer; only offsets 0..2 are valid.
//  - TC_WE[i] = PrWE & hit(timer i).
//  - PrRD = TC_RD slice, or the IC register, or 0 when there is no hit or the offset is 3.
//  - Writes to unmapped addresses are dropped silently.
//  Controller registers, with offsets from IC_BASE:
//  - +0 PEND: [N_TC-1:0] pending, [N_TC+7:8] overrun. Read/write-1-to-clear; other bits read 0.
//  - +4 MASK: [N_TC-1:0] read/write. Reset value is all ones; other bits read 0.
//  - +8 VEC: read-only. [31] = any(PEND & MASK); [3:0] = lowest index i with PEND[i] & MASK[i], else 0.
//  Edge capture:
//  - irq_q[i] <= TC_IRQ[i] every cycle.
//  - A rise is TC_IRQ[i] & ~irq_q[i].
//  - A rise sampled at edge k sets PEND[i] after edge k, so HWInt is visible in cycle k+1 (1-cycle latency).
//  - A rise while PEND[i] is already 1 sets OVR[i]. PEND stays 1.
//  - A level held high does not re-trigger; a new rise needs a low cycle first.
//  Simultaneous events, same cycle:
//  - W1C of PEND[i] together with a rise on i: PEND[i] ends at 1 (set wins) and OVR is unchanged.
//  - W1C of OVR[i] together with a rise on i while PEND[i]=1: OVR[i] ends at 1.
//  - MASK only gates HWInt and VEC. Masked sources still latch PEND and OVR.
//  - A MASK write takes effect after the edge. PrRD reflects register state before the edge.
//  - A CPU write to a timer passes through in the same cycle; the bridge adds no state.
//  Reset (any cycle, including mid-write):
//  - PEND=0, OVR=0, MASK=all ones, irq_q=0.
//  - All outputs settle to HWInt=0 except EXT_IRQ passthrough, TC_WE=0 unless PrWE hits, and PrRD per decode.
//  - A TC_IRQ high at the first post-reset edge counts as a rise.
//  There is no FSM beyond the per-source pending/overrun bits.
// TESTING
//  1. Decode, N_TC=2, with reset applied:
//     - Write 0x7F14 <= 0x64: TC_WE=2'b10 for exactly that cycle.
//     - Read 0x7F14 returns TC_RD[63:32].
//     - Read 0x7F0C or 0x7F80 returns 0 and TC_WE=0.
//  2. Edge latch:
//     - Raise TC_IRQ[0] at edge 5 and hold it: PEND=0x1 and HWInt[0]=1 from cycle 6.
//     - VEC=0x80000000.
//     - Holding the level 10 cycles sets no OVR.
//  3. Priority/mask:
//     - Raise both IRQs: VEC[3:0]=0.
//     - Write MASK=0x2: HWInt[1:0]=2'b10 and VEC=0x80000001 after the edge.
//     - Write MASK=0: VEC=0 and HWInt[1:0]=0, while PEND still reads 0x3.
//  4. Overrun:
//     - Timer 1 pulses high/low/high without a clear: PEND=0x2 and OVR reads PEND[9]=1.
//     - Write PEND=0x202: both bits clear.
//  5. Simultaneous:
//     - W1C PEND=0x1 in the same cycle as a new rise on IRQ0: PEND[0]=1 after the edge and OVR[0] unchanged.
//  6. Reset mid-operation:
//     - PEND=0x3, MASK=0x1, then assert reset 1 cycle: PEND=0, MASK=0x3, HWInt[1:0]=0.
//     - IRQ0 held high through reset: PEND[0]=1 one cycle after deassert.

Source files
------------

// File: rtl/tc_bridge_intc.sv
// Bus bridge between the CPU memory stage and N_TC timers, plus a small
// edge-latching interrupt controller that produces the 6-bit HWInt for CP0.
module tc_bridge_intc #(
  parameter int          N_TC    = 2,
  parameter logic [31:0] TC_BASE = 32'h7F00,
  parameter logic [31:0] IC_BASE = 32'h7F40
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [29:0]         PrAddr,
  input  logic                PrWE,
  input  logic [31:0]         PrWD,
  output logic [31:0]         PrRD,
  output logic [29:0]         DEV_Addr,
  output logic [31:0]         DEV_WD,
  output logic [N_TC-1:0]     TC_WE,
  input  logic [32*N_TC-1:0]  TC_RD,
  input  logic [N_TC-1:0]     TC_IRQ,
  input  logic [5-N_TC:0]     EXT_IRQ,
  output logic [5:0]          HWInt
);

  logic [27:0]     blk;
  logic [1:0]      off;
  logic            ic_hit;
  logic            pend_we;
  logic            mask_we;
  logic [N_TC-1:0] irq_q;
  logic [N_TC-1:0] pend;
  logic [N_TC-1:0] ovr;
  logic [N_TC-1:0] mask;
  logic [N_TC-1:0] rise;
  logic [N_TC-1:0] active;
  logic [N_TC-1:0] pend_clr;
  logic [N_TC-1:0] ovr_clr;
  logic [31:0]     pend_word;
  logic [31:0]     mask_word;
  logic [31:0]     vec_word;

  // Each timer owns one 16-byte block; blk is the byte address divided by 16.
  function automatic logic [27:0] tc_block(input int i);
    return TC_BASE[31:4] + 28'(i);
  endfunction

  assign blk      = PrAddr[29:2];
  assign off      = PrAddr[1:0];
  assign ic_hit   = (blk == IC_BASE[31:4]);
  assign pend_we  = PrWE & ic_hit & (off == 2'd0);
  assign mask_we  = PrWE & ic_hit & (off == 2'd1);
  assign DEV_Addr = PrAddr;
  assign DEV_WD   = PrWD;

  assign rise     = TC_IRQ & ~irq_q;
  assign active   = pend & mask;
  assign pend_clr = pend_we ? PrWD[N_TC-1:0]   : '0;
  assign ovr_clr  = pend_we ? PrWD[N_TC+7:8]   : '0;
  assign HWInt    = {EXT_IRQ, active};

  // A new rise always wins over a same-cycle clear; a rise only counts as an
  // overrun when the pending bit survives the cycle's W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= '0;
      pend  <= '0;
      ovr   <= '0;
      mask  <= '1;
    end else begin
      irq_q <= TC_IRQ;
      pend  <= (pend & ~pend_clr) | rise;
      ovr   <= (ovr & ~ovr_clr) | (rise & pend & ~pend_clr);
      if (mask_we) mask <= PrWD[N_TC-1:0];
    end
  end

  always_comb begin
    pend_word = '0;
    mask_word = '0;
    vec_word  = '0;
    pend_word[N_TC-1:0] = pend;
    pend_word[N_TC+7:8] = ovr;
    mask_word[N_TC-1:0] = mask;
    // Scan downward so the lowest active index is the one left standing.
    for (int i = N_TC - 1; i >= 0; i--) begin
      if (active[i]) vec_word[3:0] = 4'(i);
    end
    vec_word[31] = |active;
  end

  always_comb begin
    TC_WE = '0;
    PrRD  = '0;
    for (int i = 0; i < N_TC; i++) begin
      if (blk == tc_block(i) && off != 2'd3) begin
        TC_WE[i] = PrWE;
        PrRD     = TC_RD[32*i +: 32];
      end
    end
    if (ic_hit) begin
      case (off)
        2'd0:    PrRD = pend_word;
        2'd1:    PrRD = mask_word;
        2'd2:    PrRD = vec_word;
        default: PrRD = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_bridge_intc.sv
// Self-checking bench for tc_bridge_intc: decode table, directed interrupt
// sequences and a randomized run against a behavioural model.
module tb_tc_bridge_intc;

  localparam int N_TC = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [29:0]       PrAddr;
  logic              PrWE;
  logic [31:0]       PrWD;
  logic [31:0]       PrRD;
  logic [29:0]       DEV_Addr;
  logic [31:0]       DEV_WD;
  logic [N_TC-1:0]   TC_WE;
  logic [32*N_TC-1:0] TC_RD;
  logic [N_TC-1:0]   TC_IRQ;
  logic [5-N_TC:0]   EXT_IRQ;
  logic [5:0]        HWInt;

  tc_bridge_intc #(.N_TC(N_TC)) dut (
    .clk(clk), .reset(reset), .PrAddr(PrAddr), .PrWE(PrWE), .PrWD(PrWD),
    .PrRD(PrRD), .DEV_Addr(DEV_Addr), .DEV_WD(DEV_WD), .TC_WE(TC_WE),
    .TC_RD(TC_RD), .TC_IRQ(TC_IRQ), .EXT_IRQ(EXT_IRQ), .HWInt(HWInt)
  );

  always #5 clk = ~clk;

  // Behavioural model: one flag per source, updated once per clock edge.
  bit m_pend[N_TC];
  bit m_ovr[N_TC];
  bit m_mask[N_TC];
  bit m_prev[N_TC];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] exp_rd;
    logic [1:0]  exp_we;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cur_byte_addr();
    return {PrAddr, 2'b00};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] r;
    bit found;
    r = '0;
    found = 0;
    for (int i = 0; i < N_TC; i++) begin
      if (!found && m_pend[i] && m_mask[i]) begin
        found = 1;
        r[3:0] = 4'(i);
      end
    end
    r[31] = found;
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] r;
    int idx, wrd;
    r = '0;
    if (a >= 32'h7F00 && a < 32'h7F00 + 32'(16 * N_TC)) begin
      idx = int'((a - 32'h7F00) / 16);
      wrd = int'((a % 16) / 4);
      if (wrd < 3) r = TC_RD[32*idx +: 32];
    end else if (a == 32'h7F40) begin
      for (int i = 0; i < N_TC; i++) begin
        r[i]     = m_pend[i];
        r[8 + i] = m_ovr[i];
      end
    end else if (a == 32'h7F44) begin
      for (int i = 0; i < N_TC; i++) r[i] = m_mask[i];
    end else if (a == 32'h7F48) begin
      r = model_vec();
    end
    return r;
  endfunction

  function automatic logic [N_TC-1:0] model_we(input logic [31:0] a);
    logic [N_TC-1:0] r;
    r = '0;
    for (int i = 0; i < N_TC; i++) begin
      if (a >= 32'h7F00 + 32'(16 * i) && a < 32'h7F00 + 32'(16 * i) + 12) r[i] = PrWE;
    end
    return r;
  endfunction

  function automatic logic [5:0] model_hw();
    logic [N_TC-1:0] b;
    for (int i = 0; i < N_TC; i++) b[i] = m_pend[i] & m_mask[i];
    return {EXT_IRQ, b};
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [31:0] a;
    bit rise, clr_p, clr_o;
    a = cur_byte_addr();
    for (int i = 0; i < N_TC; i++) begin
      if (reset) begin
        m_pend[i] = 0;
        m_ovr[i]  = 0;
        m_mask[i] = 1;
        m_prev[i] = 0;
      end else begin
        rise  = TC_IRQ[i] && !m_prev[i];
        clr_p = PrWE && a == 32'h7F40 && PrWD[i];
        clr_o = PrWE && a == 32'h7F40 && PrWD[8 + i];
        if (clr_o) m_ovr[i] = 0;
        if (rise && m_pend[i] && !clr_p) m_ovr[i] = 1;
        if (clr_p) m_pend[i] = 0;
        if (rise) m_pend[i] = 1;
        if (PrWE && a == 32'h7F44) m_mask[i] = PrWD[i];
        m_prev[i] = TC_IRQ[i];
      end
    end
  endtask

  task automatic check_output();
    #1;
    check("PrRD", PrRD, model_rd(cur_byte_addr()));
    check("TC_WE", 32'(TC_WE), 32'(model_we(cur_byte_addr())));
    check("HWInt", 32'(HWInt), 32'(model_hw()));
    check("DEV_WD", DEV_WD, PrWD);
  endtask

  task automatic tick();
    check_output();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic we, input logic [31:0] wd);
    PrAddr = a[31:2];
    PrWE   = we;
    PrWD   = wd;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    apply_stimulus(a, 1'b0, 32'h0);
    #1;
    check(name, PrRD, exp);
  endtask

  logic [31:0] addr_pool[16] = '{32'h7F00, 32'h7F04, 32'h7F08, 32'h7F0C,
                                 32'h7F10, 32'h7F14, 32'h7F18, 32'h7F1C,
                                 32'h7F20, 32'h7F40, 32'h7F44, 32'h7F48,
                                 32'h7F4C, 32'h7F50, 32'h0000, 32'h7F3C};

  initial begin
    logic [31:0] a, wd;
    logic we;

    tbl[0]  = '{32'h0000_7F14, 1'b1, 32'hBBBB_2222, 2'b10};
    tbl[1]  = '{32'h0000_7F14, 1'b0, 32'hBBBB_2222, 2'b00};
    tbl[2]  = '{32'h0000_7F0C, 1'b1, 32'h0000_0000, 2'b00};
    tbl[3]  = '{32'h0000_7F80, 1'b1, 32'h0000_0000, 2'b00};
    tbl[4]  = '{32'h0000_7F00, 1'b1, 32'hAAAA_1111, 2'b01};
    tbl[5]  = '{32'h0000_7F08, 1'b0, 32'hAAAA_1111, 2'b00};
    tbl[6]  = '{32'h0000_7F1C, 1'b1, 32'h0000_0000, 2'b00};
    tbl[7]  = '{32'h0000_7F18, 1'b1, 32'hBBBB_2222, 2'b10};
    tbl[8]  = '{32'h0000_7F20, 1'b1, 32'h0000_0000, 2'b00};
    tbl[9]  = '{32'h0000_7F44, 1'b0, 32'h0000_0003, 2'b00};
    tbl[10] = '{32'h0000_7F4C, 1'b0, 32'h0000_0000, 2'b00};
    tbl[11] = '{32'h0001_7F14, 1'b1, 32'h0000_0000, 2'b00};
    tbl[12] = '{32'h0000_7F40, 1'b0, 32'h0000_0000, 2'b00};
    tbl[13] = '{32'h0000_7F48, 1'b0, 32'h0000_0000, 2'b00};

    reset   = 1'b1;
    TC_IRQ  = '0;
    EXT_IRQ = '0;
    TC_RD   = 64'hBBBB_2222_AAAA_1111;
    apply_stimulus(32'h7F00, 1'b0, 32'h0);
    repeat (2) begin
      @(posedge clk);
      model_step();
    end
    #1;
    reset = 1'b0;

    read_check("rst_pend", 32'h7F40, 32'h0);
    read_check("rst_mask", 32'h7F44, 32'h3);
    check("rst_hwint", 32'(HWInt), 32'h0);

    for (int k = 0; k < 14; k++) begin
      apply_stimulus(tbl[k].addr, tbl[k].we, 32'h64);
      #1;
      check($sformatf("tbl%0d_rd", k), PrRD, tbl[k].exp_rd);
      check($sformatf("tbl%0d_we", k), 32'(TC_WE), 32'(tbl[k].exp_we));
      tick();
    end

    $display("[TB] edge latch");
    apply_stimulus(32'h7F40, 1'b0, 32'h0);
    tick();
    TC_IRQ = 2'b01;
    #1;
    check("hw_latency", 32'(HWInt[1:0]), 32'h0);
    tick();
    read_check("pend_set", 32'h7F40, 32'h1);
    check("hw0_set", 32'(HWInt[0]), 32'h1);
    read_check("vec_one", 32'h7F48, 32'h8000_0000);
    repeat (10) tick();
    read_check("no_ovr_hold", 32'h7F40, 32'h1);

    $display("[TB] priority and mask");
    TC_IRQ = 2'b11;
    tick();
    read_check("pend_both", 32'h7F40, 32'h3);
    read_check("vec_pri", 32'h7F48, 32'h8000_0000);
    apply_stimulus(32'h7F44, 1'b1, 32'h2);
    tick();
    read_check("vec_mask2", 32'h7F48, 32'h8000_0001);
    check("hw_mask2", 32'(HWInt[1:0]), 32'h2);
    apply_stimulus(32'h7F44, 1'b1, 32'h0);
    tick();
    read_check("vec_mask0", 32'h7F48, 32'h0);
    check("hw_mask0", 32'(HWInt[1:0]), 32'h0);
    read_check("pend_masked", 32'h7F40, 32'h3);

    $display("[TB] overrun");
    apply_stimulus(32'h7F44, 1'b1, 32'h3);
    tick();
    TC_IRQ = 2'b00;
    apply_stimulus(32'h7F40, 1'b1, 32'h303);
    tick();
    read_check("pend_clr", 32'h7F40, 32'h0);
    TC_IRQ = 2'b10; tick();
    TC_IRQ = 2'b00; tick();
    TC_IRQ = 2'b10; tick();
    read_check("ovr_set", 32'h7F40, 32'h202);
    apply_stimulus(32'h7F40, 1'b1, 32'h202);
    tick();
    read_check("ovr_clr", 32'h7F40, 32'h0);

    $display("[TB] simultaneous events");
    TC_IRQ = 2'b00; tick();
    TC_IRQ = 2'b01; tick();
    TC_IRQ = 2'b00; tick();
    read_check("pend0_pre", 32'h7F40, 32'h1);
    TC_IRQ = 2'b01;
    apply_stimulus(32'h7F40, 1'b1, 32'h1);
    tick();
    read_check("w1c_vs_rise", 32'h7F40, 32'h1);
    TC_IRQ = 2'b00; tick();
    TC_IRQ = 2'b01; tick();
    read_check("ovr0_set", 32'h7F40, 32'h101);
    TC_IRQ = 2'b00; tick();
    TC_IRQ = 2'b01;
    apply_stimulus(32'h7F40, 1'b1, 32'h100);
    tick();
    read_check("ovrclr_vs_rise", 32'h7F40, 32'h101);

    $display("[TB] reset mid-operation");
    TC_IRQ = 2'b11;
    tick();
    apply_stimulus(32'h7F40, 1'b1, 32'h100);
    tick();
    apply_stimulus(32'h7F44, 1'b1, 32'h1);
    tick();
    read_check("pre_rst_pend", 32'h7F40, 32'h3);
    read_check("pre_rst_mask", 32'h7F44, 32'h1);
    TC_IRQ = 2'b01;
    reset  = 1'b1;
    apply_stimulus(32'h7F44, 1'b1, 32'h2);
    tick();
    reset = 1'b0;
    read_check("post_rst_pend", 32'h7F40, 32'h0);
    read_check("post_rst_mask", 32'h7F44, 32'h3);
    check("post_rst_hw", 32'(HWInt[1:0]), 32'h0);
    tick();
    read_check("held_irq_rise", 32'h7F40, 32'h1);

    $display("[TB] randomized run");
    for (int n = 0; n < 400; n++) begin
      a = addr_pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000;
      we = 1'($urandom_range(0, 1));
      wd = $urandom();
      if ($urandom_range(0, 1) == 1) wd = wd & 32'h0000_0303;
      TC_IRQ  = 2'($urandom_range(0, 3));
      EXT_IRQ = 4'($urandom_range(0, 15));
      TC_RD   = {$urandom(), $urandom()};
      reset   = ($urandom_range(0, 49) == 0);
      apply_stimulus(a, we, wd);
      tick();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
